// File: rtl/bless_sw_traverse_pkg.sv
// rtl/bless_sw_traverse_pkg.sv - shared router constants and port indices for the switch-traversal stage
package bless_sw_traverse_pkg;
  localparam int FLIT_W         = 128;
  localparam int NUM_PORT       = 5;
  localparam int NUM_OUT        = NUM_PORT - 1;
  localparam int PC_INDEX_WIDTH = 3;

  // Network links come first; the local port is the last index.
  typedef enum logic [PC_INDEX_WIDTH-1:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;
endpackage

// File: rtl/bless_sw_traverse_eject_fifo.sv
// rtl/bless_sw_traverse_eject_fifo.sv - ejection FIFO with wrap-bit pointers and registered near-full flag
module bless_sw_traverse_eject_fifo
  import bless_sw_traverse_pkg::*;
#(
  parameter int W     = 128,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         almost_full,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr, rd_ptr, count, count_next;
  logic [W-1:0] mem [DEPTH];
  logic         empty, full, do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  // A pop on a full FIFO frees the slot the simultaneous push lands in.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;

  assign count      = wr_ptr - rd_ptr;
  assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

  assign valid = !empty;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      almost_full <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      almost_full <= (count_next >= (AW+1)'(DEPTH - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/bless_sw_traverse.sv
// rtl/bless_sw_traverse.sv - crossbar traversal, registered output links and local ejection (STATS_EN adds per-port counters)
module bless_sw_traverse
  import bless_sw_traverse_pkg::*;
#(
  parameter int FLIT_W   = bless_sw_traverse_pkg::FLIT_W,
  parameter int NUM_IN   = 4,
  parameter int EJ_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_IN*FLIT_W-1:0]   flit_in,
  input  logic [NUM_IN-1:0]          flit_vld_in,
  input  logic [NUM_IN*NUM_OUT-1:0]  alloc_vec_in,
  input  logic [NUM_IN-1:0]          eject_in,
  output logic [NUM_OUT*FLIT_W-1:0]  flit_out,
  output logic [NUM_OUT-1:0]         flit_vld_out,
  output logic [FLIT_W-1:0]          ej_flit,
  output logic                       ej_valid,
  input  logic                       ej_ready,
  output logic                       ej_full,
`ifdef STATS_EN
  input  logic                       stat_clr,
  output logic [NUM_OUT*16-1:0]      stat_port_cnt,
`endif
  output logic                       err_conflict
);
  logic [NUM_OUT-1:0]        sel_vld;
  logic [NUM_OUT*FLIT_W-1:0] sel_flit;
  logic                      link_conflict, ej_push, ej_multi, ej_drop;
  logic [FLIT_W-1:0]         ej_push_flit;

  // Scan slots in ascending order so the lowest index claims each port and the eject slot.
  always_comb begin
    sel_vld       = '0;
    sel_flit      = flit_out;
    link_conflict = 1'b0;
    ej_push       = 1'b0;
    ej_multi      = 1'b0;
    ej_push_flit  = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (flit_vld_in[i]) begin
        for (int p = 0; p < NUM_OUT; p++) begin
          if (alloc_vec_in[i*NUM_OUT + p]) begin
            if (sel_vld[p]) begin
              link_conflict = 1'b1;
            end else begin
              sel_vld[p] = 1'b1;
              sel_flit[p*FLIT_W +: FLIT_W] = flit_in[i*FLIT_W +: FLIT_W];
            end
          end
        end
        if (eject_in[i]) begin
          if (ej_push) begin
            ej_multi = 1'b1;
          end else begin
            ej_push      = 1'b1;
            ej_push_flit = flit_in[i*FLIT_W +: FLIT_W];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      flit_out     <= '0;
      flit_vld_out <= '0;
      err_conflict <= 1'b0;
    end else begin
      flit_out     <= sel_flit;
      flit_vld_out <= sel_vld;
      if (link_conflict || ej_multi || ej_drop) err_conflict <= 1'b1;
    end
  end

  bless_sw_traverse_eject_fifo #(
    .W     (FLIT_W),
    .DEPTH (EJ_DEPTH)
  ) u_eject_fifo (
    .clk         (clk),
    .n_rst       (n_rst),
    .push        (ej_push),
    .push_data   (ej_push_flit),
    .pop         (ej_ready),
    .head        (ej_flit),
    .valid       (ej_valid),
    .almost_full (ej_full),
    .drop        (ej_drop)
  );

`ifdef STATS_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      stat_port_cnt <= '0;
    end else begin
      for (int p = 0; p < NUM_OUT; p++) begin
        if (stat_clr)
          stat_port_cnt[p*16 +: 16] <= '0;
        else if (sel_vld[p] && stat_port_cnt[p*16 +: 16] != 16'hFFFF)
          stat_port_cnt[p*16 +: 16] <= stat_port_cnt[p*16 +: 16] + 16'd1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_bless_sw_traverse.sv
// tb/tb_bless_sw_traverse.sv - scoreboard bench for the switch-traversal stage
module tb_bless_sw_traverse;
  import bless_sw_traverse_pkg::*;

  localparam int W     = 128;
  localparam int NI    = 4;
  localparam int NO    = 4;
  localparam int DEPTH = 4;

  logic              clk, n_rst;
  logic [NI*W-1:0]   flit_in;
  logic [NI-1:0]     flit_vld_in, eject_in;
  logic [NI*NO-1:0]  alloc_vec_in;
  logic [NO*W-1:0]   flit_out;
  logic [NO-1:0]     flit_vld_out;
  logic [W-1:0]      ej_flit;
  logic              ej_valid, ej_ready, ej_full, err_conflict;
`ifdef STATS_EN
  logic              stat_clr;
  logic [NO*16-1:0]  stat_cnt;
`endif

  bless_sw_traverse #(.FLIT_W(W), .NUM_IN(NI), .EJ_DEPTH(DEPTH)) dut (
    .clk(clk), .n_rst(n_rst), .flit_in(flit_in), .flit_vld_in(flit_vld_in),
    .alloc_vec_in(alloc_vec_in), .eject_in(eject_in), .flit_out(flit_out),
    .flit_vld_out(flit_vld_out), .ej_flit(ej_flit), .ej_valid(ej_valid),
    .ej_ready(ej_ready), .ej_full(ej_full),
`ifdef STATS_EN
    .stat_clr(stat_clr), .stat_port_cnt(stat_cnt),
`endif
    .err_conflict(err_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NO-1:0]   vld;
    logic [NO*W-1:0] flit;
    logic            err;
    logic            ejv;
    logic            ejf;
  } exp_t;

  exp_t           link_q[$];
  logic [W-1:0]   ej_q[$];
  logic [NO*W-1:0] held;
  int             mcnt;
  logic           err_m;
  int             tests, fails;

  function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [W-1:0] rand_flit();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle of stimulus; the model applies the switch rules to compute the post-edge state.
  task automatic drive(input logic [NI*W-1:0] f, input logic [NI-1:0] v,
                       input logic [NI*NO-1:0] a, input logic [NI-1:0] e, input logic r);
    exp_t x;
    int hits, nej;
    logic pop, acc;
    logic [W-1:0] pf;
    @(negedge clk);
    flit_in = f; flit_vld_in = v; alloc_vec_in = a; eject_in = e; ej_ready = r;
    x.vld = '0;
    pf = '0;
    for (int p = 0; p < NO; p++) begin
      hits = 0;
      for (int i = 0; i < NI; i++) begin
        if (v[i] && a[i*NO + p]) begin
          if (hits == 0) begin
            x.vld[p] = 1'b1;
            held[p*W +: W] = f[i*W +: W];
          end
          hits++;
        end
      end
      if (hits > 1) err_m = 1'b1;
    end
    nej = 0;
    for (int i = 0; i < NI; i++) begin
      if (v[i] && e[i]) begin
        if (nej == 0) pf = f[i*W +: W];
        nej++;
      end
    end
    if (nej > 1) err_m = 1'b1;
    pop = r && (mcnt > 0);
    acc = (nej > 0) && ((mcnt < DEPTH) || pop);
    if (nej > 0 && !acc) err_m = 1'b1;
    if (acc) ej_q.push_back(pf);
    mcnt = mcnt + int'(acc) - int'(pop);
    x.flit = held;
    x.err  = err_m;
    x.ejv  = (mcnt > 0);
    x.ejf  = (mcnt >= DEPTH - 1);
    link_q.push_back(x);
  endtask

  task automatic idle(input int n, input logic r);
    for (int k = 0; k < n; k++) drive(rand_flit(), '0, 16'($urandom), 4'($urandom), r);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    flit_vld_in = '0; eject_in = '0; ej_ready = 1'b0;
    #1;
    chk("rst_flit_vld_out", flit_vld_out, 0);
    chk("rst_flit_out", flit_out, 0);
    chk("rst_ej_valid", ej_valid, 0);
    chk("rst_ej_full", ej_full, 0);
    chk("rst_err_conflict", err_conflict, 0);
    link_q.delete(); ej_q.delete();
    held = '0; mcnt = 0; err_m = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  initial begin : link_monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (link_q.size() > 0) begin
        x = link_q.pop_front();
        chk("flit_vld_out", flit_vld_out, x.vld);
        chk("flit_out", flit_out, x.flit);
        chk("err_conflict", err_conflict, x.err);
        chk("ej_valid", ej_valid, x.ejv);
        chk("ej_full", ej_full, x.ejf);
      end
    end
  end

  initial begin : ej_monitor
    forever begin
      @(negedge clk);
      #2;
      if (n_rst && ej_valid && ej_ready) begin
        if (ej_q.size() == 0) chk("ej_unexpected_pop", 1, 0);
        else chk("ej_flit", ej_flit, ej_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    logic [NI*W-1:0]  f;
    logic [NI*NO-1:0] a;
    logic [NI-1:0]    v, e;
    int s;
    tests = 0; fails = 0;
    held = '0; mcnt = 0; err_m = 1'b0;
    n_rst = 1'b1;
    flit_in = '0; flit_vld_in = '0; alloc_vec_in = '0; eject_in = '0; ej_ready = 1'b0;
`ifdef STATS_EN
    stat_clr = 1'b0;
`endif
    #2 n_rst = 1'b0;
    #1;
    chk("reset_flit_vld_out", flit_vld_out, 0);
    chk("reset_flit_out", flit_out, 0);
    chk("reset_ej_valid", ej_valid, 0);
    chk("reset_ej_full", ej_full, 0);
    chk("reset_err_conflict", err_conflict, 0);
    #9 n_rst = 1'b1;

    // Unicast: slot0->E, slot1->N, slot2->W, slot3->S
    f = {128'hDDDD, 128'hCCCC, 128'hBBBB, 128'hAAAA};
    a = '0;
    a[0*NO + PORT_E] = 1'b1;
    a[1*NO + PORT_N] = 1'b1;
    a[2*NO + PORT_W] = 1'b1;
    a[3*NO + PORT_S] = 1'b1;
    drive(f, 4'b1111, a, 4'b0000, 1'b0);

    // Multicast on N and S plus local ejection
    f = {rand_flit(), rand_flit(), {16{8'h55}}, rand_flit()};
    drive(f, 4'b0010, 16'h0050, 4'b0010, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // Conflict-free random traffic with back-pressure honoured
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NI; i++) f[i*W +: W] = rand_flit();
      v = 4'($urandom);
      a = '0;
      for (int p = 0; p < NO; p++) begin
        s = $urandom_range(0, 5);
        if (s < NI) a[s*NO + p] = 1'b1;
      end
      e = '0;
      if (!ej_full && ($urandom % 2 == 1)) e[$urandom_range(0, NI-1)] = 1'b1;
      drive(f, v, a, e, 1'($urandom));
    end
    idle(8, 1'b1);

    // FIFO fill: third push raises ej_full, fifth is dropped
    for (int k = 1; k <= 5; k++) drive({384'h0, 128'(k)}, 4'b0001, 16'h0000, 4'b0001, 1'b0);
    // Push and pop together while full
    for (int k = 6; k <= 8; k++) drive({384'h0, 128'(k)}, 4'b0001, 16'h0000, 4'b0001, 1'b1);
    idle(8, 1'b1);

    // Two entries queued and links valid, then asynchronous reset
    drive({rand_flit(), rand_flit(), rand_flit(), rand_flit()}, 4'b0001, 16'h000F, 4'b0001, 1'b0);
    drive({rand_flit(), rand_flit(), rand_flit(), rand_flit()}, 4'b0010, 16'h00F0, 4'b0010, 1'b0);
    async_reset_check();

    // Port conflict and multiple eject after reset
    f = {rand_flit(), rand_flit(), rand_flit(), rand_flit()};
    drive(f, 4'b1111, 16'h0011, 4'b0110, 1'b0);
    idle(6, 1'b1);

    @(posedge clk);
    #2;
    chk("scoreboard_links_drained", link_q.size(), 0);
    chk("scoreboard_ej_drained", ej_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bless_sw_traverse.md
Name: bless_sw_traverse

Overview:
- Switch-traversal and output stage downstream of the BLESS/CARPOOL sequential port allocator.
- Consumes the per-flit allocated port vectors and drives registered N/E/S/W output links. A multicast flit with more than one allocated bit is replicated onto every allocated port.
- Flits marked for local ejection go into a small ejection FIFO drained by the core through a valid/ready handshake.
- Sits between the allocator chain and the inter-router links; reports ejection back-pressure to the allocator.

Parameters:
- FLIT_W, 128, flit width in bits including header.
- NUM_IN, 4, number of network input flits per cycle (= `NUM_PORT-1).
- EJ_DEPTH, 4, ejection FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- n_rst  in  1  asynchronous active-low reset.
- flit_in  in  NUM_IN*FLIT_W  input flits; slot i is bits [i*FLIT_W +: FLIT_W].
- flit_vld_in  in  NUM_IN  slot valid.
- alloc_vec_in  in  NUM_IN*(`NUM_PORT-1)  allocatedPortVector per slot; bit order N, E, S, W.
- eject_in  in  NUM_IN  slot is ejected locally this cycle.
- flit_out  out  (`NUM_PORT-1)*FLIT_W  registered output link data.
- flit_vld_out  out  `NUM_PORT-1  registered output link valid.
- ej_flit  out  FLIT_W  FIFO head.
- ej_valid  out  1  FIFO non-empty.
- ej_ready  in  1  core accepts the head flit.
- ej_full  out  1  registered; FIFO cannot take a flit next cycle.
- err_conflict  out  1  sticky error flag.

Behaviour:
- Output links: 1-cycle latency. At posedge, for each port p, flit_out[p] <= the flit of the unique valid slot i with alloc_vec_in[i][p] = 1; flit_vld_out[p] <= 1. If no slot targets p, flit_vld_out[p] <= 0 and flit_out[p] holds its old value.
- Multicast: one slot with multiple alloc bits → identical copies on each allocated port in the same cycle.
- Port conflict: two valid slots targeting the same port → lowest slot index wins; err_conflict set, sticky until reset.
- Invalid slots: alloc and eject bits are ignored.
- A slot may be both ejected and forwarded (multicast with local destination); both actions occur.
- Ejection: at most one eject per cycle. If several eject_in bits are set, the lowest valid index is pushed and err_conflict is set.
- FIFO pointers are log2(EJ_DEPTH)+1 bits with a wrap bit.
  - full: pointer indices equal, wrap bits differ.
  - empty: pointers equal.
- Push and pop in the same cycle:
  - FIFO empty: the push is written and the pop is ignored (ej_valid is 0, so no pop).
  - FIFO full: the pop frees the entry, the push is accepted, and the count is unchanged.
- Push while full with no pop → flit dropped and err_conflict set. The allocator must prevent this by honouring ej_full.
- ej_full <= (count_next >= EJ_DEPTH-1), giving one cycle of slack for the registered back-pressure.
- ej_flit is the combinational read of the head entry; it is stable while ej_valid=1 and ej_ready=0.
- Reset (async, any cycle, including mid-transfer):
  - flit_vld_out=0, flit_out=0, pointers=0, ej_valid=0, ej_full=0, err_conflict=0.
  - FIFO contents are discarded.

Optional Feature:
- STATS_EN defined:
  - Adds output stat_port_cnt (`NUM_PORT-1)*16 and input stat_clr.
  - Each port's counter increments when flit_vld_out rises for that cycle; it saturates at 16'hFFFF.
  - stat_clr zeroes all counters synchronously and has priority over increment.
  - Counters reset to 0.
- Undefined: no counters and no extra ports; everything else is identical.

Decomposition:
- Shared package/global.vh holds FLIT_W, `NUM_PORT, `PC_INDEX_WIDTH, the port index constants N=0/E=1/S=2/W=3, and the flit header field offsets.
- One natural sub-module: eject_fifo, a parameterised synchronous FIFO with full/empty/count and async active-low reset.
- The crossbar mux and registers stay in the top module.

Test Plan:
- Unicast, all ports: slot0 → E, slot1 → N, slot2 → W, slot3 → S, distinct data A..D → next cycle flit_out E=A, N=B, W=C, S=D; flit_vld_out=4'b1111.
- Multicast: slot1 data 0x55.., alloc=4'b0101, eject_in[1]=1 → next cycle N and S both carry 0x55..; FIFO holds 0x55..; ej_valid=1.
- Idle: all flit_vld_in=0 → flit_vld_out=0 next cycle; flit_out unchanged.
- FIFO fill: EJ_DEPTH=4, ej_ready=0, one eject per cycle.
  - ej_full asserts the cycle after the 3rd push.
  - 5th push with no pop → dropped, err_conflict=1.
  - Draining gives FIFO order 1..4.
- Simultaneous push/pop when full → count stays 4, order preserved, no error.
- Reset mid-operation: assert n_rst asynchronously with the FIFO holding 2 and links valid → all outputs 0 immediately, before the next clock edge.
- STATS_EN: 3 cycles of traffic on E → counter E=3; stat_clr → 0; counter preloaded at 0xFFFF stays 0xFFFF.
